// File: rtl/l1i_miss_ctrl_pkg.sv
// Shared types and default sizes for the L1 instruction-cache miss controller.
// Address layout is tag / set / offset, most significant first.
package l1i_miss_ctrl_pkg;

    localparam int NUM_WARPS_PER_SM       = 4;
    localparam int NUM_WARPS_PER_SM_WIDTH = $clog2(NUM_WARPS_PER_SM);
    localparam int NUM_L1I_WAYS           = 4;
    localparam int NUM_L1I_SETS           = 64;
    localparam int L1I_TAG_WIDTH          = 20;
    localparam int L1I_LINE_BITS          = 512;
    localparam int L1I_SET_WIDTH          = $clog2(NUM_L1I_SETS);
    localparam int L1I_OFFSET_WIDTH       = 32 - L1I_TAG_WIDTH - L1I_SET_WIDTH;

    typedef struct packed {
        logic [L1I_TAG_WIDTH-1:0]    tag;
        logic [L1I_SET_WIDTH-1:0]    set_idx;
        logic [L1I_OFFSET_WIDTH-1:0] offset;
    } l1i_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } l1i_miss_state_t;

endpackage

// File: rtl/l1i_miss_ctrl_arb.sv
// Round-robin arbiter over the pending-warp slots with one-hot and index grant outputs.
// The pointer moves past the winner only when the caller consumes the grant.
module l1i_miss_ctrl_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic             grant_valid,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    assign grant_valid = |req;

    // Search starting at the pointer and wrapping around.
    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                grant_oh[cand] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l1i_miss_ctrl.sv
// L1I miss sequencer: records per-warp misses, fills one line at a time into a
// round-robin victim way, and wakes every warp waiting on the filled line.
module l1i_miss_ctrl
    import l1i_miss_ctrl_pkg::*;
#(
    parameter int  NUM_WARPS_PER_SM = l1i_miss_ctrl_pkg::NUM_WARPS_PER_SM,
    parameter int  NUM_L1I_WAYS     = l1i_miss_ctrl_pkg::NUM_L1I_WAYS,
    parameter int  NUM_L1I_SETS     = l1i_miss_ctrl_pkg::NUM_L1I_SETS,
    parameter int  L1I_TAG_WIDTH    = l1i_miss_ctrl_pkg::L1I_TAG_WIDTH,
    parameter int  L1I_LINE_BITS    = l1i_miss_ctrl_pkg::L1I_LINE_BITS,
    localparam int WIDX_W           = (NUM_WARPS_PER_SM > 1) ? $clog2(NUM_WARPS_PER_SM) : 1,
    localparam int SET_W            = $clog2(NUM_L1I_SETS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss_valid,
    input  logic [WIDX_W-1:0]           miss_warp_idx,
    input  logic [31:0]                 miss_addr,
    output logic [NUM_WARPS_PER_SM-1:0] warp_stall_mask,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_addr,
    input  logic                        mem_resp_valid,
    input  logic [L1I_LINE_BITS-1:0]    mem_resp_data,
    output logic                        tag_we,
    output logic                        data_we,
    output logic [NUM_L1I_WAYS-1:0]     fill_way_oh,
    output logic [SET_W-1:0]            fill_set,
    output logic [L1I_TAG_WIDTH-1:0]    fill_tag,
    output logic [L1I_LINE_BITS-1:0]    fill_line,
    output logic [NUM_WARPS_PER_SM-1:0] wake_mask
);

    localparam int W      = NUM_WARPS_PER_SM;
    localparam int LINE_W = L1I_TAG_WIDTH + SET_W;
    localparam int OFF_W  = 32 - LINE_W;
    localparam int WAY_W  = (NUM_L1I_WAYS > 1) ? $clog2(NUM_L1I_WAYS) : 1;

    l1i_miss_state_t state_q, state_d;

    logic [W-1:0]             pending_q, pending_d;
    logic [LINE_W-1:0]        line_q [W];
    logic [LINE_W-1:0]        line_d [W];
    logic [LINE_W-1:0]        cur_line_q, cur_line_d;
    logic [L1I_LINE_BITS-1:0] fill_data_q, fill_data_d;
    logic [WAY_W-1:0]         victim_q [NUM_L1I_SETS];
    logic [WAY_W-1:0]         victim_d [NUM_L1I_SETS];

    logic [LINE_W-1:0] miss_line;
    logic [W-1:0]      miss_oh;
    logic              miss_new;
    logic              miss_hits_fill;
    logic [SET_W-1:0]  cur_set;
    logic [W-1:0]      wake;
    logic              unused_offset;

    logic              grant_valid;
    logic [W-1:0]      grant_oh;
    logic [WIDX_W-1:0] grant_idx;
    logic              grant_take;

    assign miss_line      = miss_addr[31:OFF_W];
    assign unused_offset  = ^miss_addr[OFF_W-1:0];
    assign miss_oh        = miss_valid ? (W'(1) << miss_warp_idx) : '0;
    assign miss_new       = miss_valid && !pending_q[miss_warp_idx];
    assign miss_hits_fill = (state_q == FILL) && (miss_line == cur_line_q);
    assign cur_set        = cur_line_q[SET_W-1:0];
    assign grant_take     = (state_q == IDLE) && grant_valid;

    // A warp is masked combinationally in the very cycle it misses.
    assign warp_stall_mask = pending_q | miss_oh;
    assign wake_mask       = wake;

    l1i_miss_ctrl_arb #(
        .N     (W),
        .IDX_W (WIDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (pending_q),
        .advance     (grant_take),
        .grant_valid (grant_valid),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx)
    );

    // A miss on the line being filled right now is woken instead of recorded,
    // which keeps it from triggering a duplicate fill.
    always_comb begin
        pending_d = pending_q;
        line_d    = line_q;
        wake      = '0;
        if (state_q == FILL) begin
            for (int i = 0; i < W; i++) begin
                if (pending_q[i] && (line_q[i] == cur_line_q)) begin
                    wake[i]      = 1'b1;
                    pending_d[i] = 1'b0;
                end
            end
        end
        if (miss_new) begin
            if (miss_hits_fill) begin
                wake[miss_warp_idx] = 1'b1;
            end else begin
                pending_d[miss_warp_idx] = 1'b1;
                line_d[miss_warp_idx]    = miss_line;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant_valid)    state_d = REQ;
            REQ:  if (mem_req_ready)  state_d = WAIT;
            WAIT: if (mem_resp_valid) state_d = FILL;
            FILL:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_line_d  = cur_line_q;
        fill_data_d = fill_data_q;
        victim_d    = victim_q;
        if (grant_take) begin
            cur_line_d = line_q[grant_idx];
        end
        if ((state_q == WAIT) && mem_resp_valid) begin
            fill_data_d = mem_resp_data;
        end
        if (state_q == FILL) begin
            if (victim_q[cur_set] == WAY_W'(NUM_L1I_WAYS - 1)) begin
                victim_d[cur_set] = '0;
            end else begin
                victim_d[cur_set] = victim_q[cur_set] + WAY_W'(1);
            end
        end
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        tag_we        = 1'b0;
        data_we       = 1'b0;
        fill_way_oh   = '0;
        fill_set      = '0;
        fill_tag      = '0;
        fill_line     = '0;
        unique case (state_q)
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {cur_line_q, {OFF_W{1'b0}}};
            end
            FILL: begin
                tag_we      = 1'b1;
                data_we     = 1'b1;
                fill_way_oh = NUM_L1I_WAYS'(1) << victim_q[cur_set];
                fill_set    = cur_set;
                fill_tag    = cur_line_q[LINE_W-1:SET_W];
                fill_line   = fill_data_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cur_line_q  <= '0;
            fill_data_q <= '0;
            for (int i = 0; i < W; i++) begin
                line_q[i] <= '0;
            end
            for (int s = 0; s < NUM_L1I_SETS; s++) begin
                victim_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_line_q  <= cur_line_d;
            fill_data_q <= fill_data_d;
            line_q      <= line_d;
            victim_q    <= victim_d;
        end
    end

endmodule
